// File: rtl/keypad_scan.sv
// 4x4 active-low matrix keypad scanner: walks one low column at a time, debounces
// press and release over whole scan samples and reports one hex code per press.
module keypad_scan #(
    parameter logic [15:0] SCAN_DIV       = 16'd50000,
    parameter logic [3:0]  DEBOUNCE_SCANS = 4'd4
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_down
);

    typedef enum logic [1:0] {
        IDLE,
        DEBOUNCE,
        PRESSED
    } state_t;

    state_t      r_state;
    state_t      w_stateNext;
    logic [3:0]  r_rowMeta;
    logic [3:0]  r_rowSync;
    logic [15:0] r_div;
    logic [1:0]  r_colIdx;
    logic [1:0]  w_colIdxNext;
    logic [3:0]  r_cand;
    logic [3:0]  w_candNext;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cntNext;
    logic [3:0]  r_keyCode;
    logic [3:0]  w_keyCodeNext;
    logic        r_keyValid;
    logic        w_keyValidNext;
    logic        r_keyDown;
    logic        w_keyDownNext;

    logic        w_sample;
    logic        w_hit;
    logic [1:0]  w_rowIdx;
    logic [3:0]  w_cntInc;
    logic        w_candRowLow;

    // Rows are idle-high, so the synchronizer resets high to avoid a phantom press.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rowMeta <= 4'hF;
            r_rowSync <= 4'hF;
            r_div     <= 16'd0;
        end else begin
            r_rowMeta <= row;
            r_rowSync <= r_rowMeta;
            r_div     <= w_sample ? 16'd0 : r_div + 16'd1;
        end
    end

    assign w_sample     = (r_div == SCAN_DIV - 16'd1);
    assign w_hit        = ~&r_rowSync;
    assign w_cntInc     = r_cnt + 4'd1;
    assign w_candRowLow = ~r_rowSync[r_cand[3:2]];

    always_comb begin
        w_rowIdx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!r_rowSync[i]) begin
                w_rowIdx = 2'(i);
            end
        end
    end

    always_comb begin
        w_stateNext    = r_state;
        w_colIdxNext   = r_colIdx;
        w_candNext     = r_cand;
        w_cntNext      = r_cnt;
        w_keyCodeNext  = r_keyCode;
        w_keyValidNext = 1'b0;
        w_keyDownNext  = r_keyDown;
        if (w_sample) begin
            unique case (r_state)
                IDLE: begin
                    if (w_hit) begin
                        w_candNext = {w_rowIdx, r_colIdx};
                        if (DEBOUNCE_SCANS == 4'd1) begin
                            w_stateNext    = PRESSED;
                            w_keyCodeNext  = {w_rowIdx, r_colIdx};
                            w_keyValidNext = 1'b1;
                            w_keyDownNext  = 1'b1;
                            w_cntNext      = 4'd0;
                        end else begin
                            w_stateNext = DEBOUNCE;
                            w_cntNext   = 4'd1;
                        end
                    end else begin
                        w_colIdxNext = r_colIdx + 2'd1;
                    end
                end
                DEBOUNCE: begin
                    if (w_hit && (w_rowIdx == r_cand[3:2])) begin
                        if (w_cntInc == DEBOUNCE_SCANS) begin
                            w_stateNext    = PRESSED;
                            w_keyCodeNext  = r_cand;
                            w_keyValidNext = 1'b1;
                            w_keyDownNext  = 1'b1;
                            w_cntNext      = 4'd0;
                        end else begin
                            w_cntNext = w_cntInc;
                        end
                    end else begin
                        w_stateNext  = IDLE;
                        w_cntNext    = 4'd0;
                        w_colIdxNext = r_colIdx + 2'd1;
                    end
                end
                PRESSED: begin
                    // Only the accepted key's row matters here; other keys are ignored.
                    if (!w_candRowLow) begin
                        if (w_cntInc == DEBOUNCE_SCANS) begin
                            w_stateNext   = IDLE;
                            w_keyDownNext = 1'b0;
                            w_cntNext     = 4'd0;
                            w_colIdxNext  = r_colIdx + 2'd1;
                        end else begin
                            w_cntNext = w_cntInc;
                        end
                    end else begin
                        w_cntNext = 4'd0;
                    end
                end
                default: begin
                    w_stateNext = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_colIdx   <= 2'd0;
            r_cand     <= 4'd0;
            r_cnt      <= 4'd0;
            r_keyCode  <= 4'd0;
            r_keyValid <= 1'b0;
            r_keyDown  <= 1'b0;
        end else begin
            r_state    <= w_stateNext;
            r_colIdx   <= w_colIdxNext;
            r_cand     <= w_candNext;
            r_cnt      <= w_cntNext;
            r_keyCode  <= w_keyCodeNext;
            r_keyValid <= w_keyValidNext;
            r_keyDown  <= w_keyDownNext;
        end
    end

    assign col       = ~(4'b0001 << r_colIdx);
    assign key_code  = r_keyCode;
    assign key_valid = r_keyValid;
    assign key_down  = r_keyDown;

endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan: a key-matrix model drives the rows from the column
// outputs, and every key_valid pulse is matched against a queue of expected codes.
module tb_keypad_scan;

    logic       clock;
    logic       reset_n;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_down;

    logic [3:0][3:0] keys;
    logic [3:0]      expQ[$];
    int              checks;
    int              errors;

    keypad_scan #(
        .SCAN_DIV       (16'd8),
        .DEBOUNCE_SCANS (4'd3)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .row       (row),
        .col       (col),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_down  (key_down)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // A pressed key at (r,c) pulls row r low while column c is driven low.
    always_comb begin
        for (int r = 0; r < 4; r++) begin
            row[r] = ~|(keys[r] & ~col);
        end
    end

    always @(negedge clock) begin
        if (reset_n && key_valid) begin
            checks++;
            if (expQ.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_key_valid got code=%h exp no pulse", key_code);
            end else begin
                logic [3:0] expCode;
                expCode = expQ.pop_front();
                if (key_code !== expCode) begin
                    errors++;
                    $display("[TB] FAIL pulse_code got %h exp %h", key_code, expCode);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog got timeout exp finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic waitCol(input logic [3:0] target, input int budget, output bit found);
        found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (col === target) begin
                found = 1'b1;
                return;
            end
            @(negedge clock);
        end
    endtask

    task automatic waitDown(input logic target, input int budget, output bit found);
        found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (key_down === target) begin
                found = 1'b1;
                return;
            end
            @(negedge clock);
        end
    endtask

    task automatic test_reset;
        bit         found;
        logic [3:0] expCol;
        logic [3:0] badCol;
        bit         ok;
        reset_n = 1'b0;
        keys    = '0;
        repeat (3) @(negedge clock);
        checks++;
        if (col !== 4'b1110) begin errors++; $display("[TB] FAIL reset_col got %b exp 1110", col); end
        checks++;
        if (key_code !== 4'h0) begin errors++; $display("[TB] FAIL reset_code got %h exp 0", key_code); end
        checks++;
        if (key_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b exp 0", key_valid); end
        checks++;
        if (key_down !== 1'b0) begin errors++; $display("[TB] FAIL reset_down got %b exp 0", key_down); end
        reset_n = 1'b1;
        waitCol(4'b1101, 20, found);
        checks++;
        if (!found) begin errors++; $display("[TB] FAIL scan_start got col=%b exp 1101", col); end
        for (int k = 0; k < 8; k++) begin
            expCol = ~(4'b0001 << ((k + 1) % 4));
            ok     = 1'b1;
            badCol = 4'h0;
            for (int j = 0; j < 8; j++) begin
                if (col !== expCol || key_down !== 1'b0 || key_code !== 4'h0) begin
                    ok     = 1'b0;
                    badCol = col;
                end
                @(negedge clock);
            end
            checks++;
            if (!ok) begin
                errors++;
                $display("[TB] FAIL scan_step%0d got col=%b exp %b for 8 cycles", k, badCol, expCol);
            end
        end
    endtask

    task automatic test_press;
        bit found;
        bit ok;
        $display("[TB] press key 9 (row2,col1)");
        keys[2][1] = 1'b1;
        expQ.push_back(4'h9);
        waitDown(1'b1, 200, found);
        checks++;
        if (!found) begin errors++; $display("[TB] FAIL press_down got %b exp 1", key_down); end
        checks++;
        if (key_code !== 4'h9) begin errors++; $display("[TB] FAIL press_code got %h exp 9", key_code); end
        checks++;
        if (col !== 4'b1101) begin errors++; $display("[TB] FAIL press_col got %b exp 1101", col); end
        repeat (2) @(negedge clock);
        checks++;
        if (expQ.size() != 0) begin errors++; $display("[TB] FAIL press_pulse got pending=%0d exp 0", expQ.size()); end
        ok = 1'b1;
        repeat (24) begin
            if (col !== 4'b1101 || key_down !== 1'b1) ok = 1'b0;
            @(negedge clock);
        end
        checks++;
        if (!ok) begin errors++; $display("[TB] FAIL press_hold got col=%b down=%b exp 1101/1", col, key_down); end
    endtask

    task automatic test_release;
        bit found;
        $display("[TB] release key 9");
        keys = '0;
        waitDown(1'b0, 100, found);
        checks++;
        if (!found) begin errors++; $display("[TB] FAIL release_down got %b exp 0", key_down); end
        checks++;
        if (key_code !== 4'h9) begin errors++; $display("[TB] FAIL release_code got %h exp 9", key_code); end
        checks++;
        if (col !== 4'b1011) begin errors++; $display("[TB] FAIL release_col got %b exp 1011", col); end
        repeat (10) @(negedge clock);
    endtask

    task automatic test_bounce;
        bit found;
        $display("[TB] one-sample bounce at col1");
        waitCol(4'b1110, 100, found);
        waitCol(4'b1101, 20, found);
        checks++;
        if (!found) begin errors++; $display("[TB] FAIL bounce_reach got col=%b exp 1101", col); end
        keys[2][1] = 1'b1;
        repeat (8) @(negedge clock);
        keys = '0;
        repeat (4) @(negedge clock);
        checks++;
        if (col !== 4'b1101) begin errors++; $display("[TB] FAIL bounce_freeze got col=%b exp 1101", col); end
        waitCol(4'b1011, 20, found);
        checks++;
        if (!found) begin errors++; $display("[TB] FAIL bounce_resume got col=%b exp 1011", col); end
        checks++;
        if (key_down !== 1'b0 || key_code !== 4'h9) begin
            errors++;
            $display("[TB] FAIL bounce_state got down=%b code=%h exp 0/9", key_down, key_code);
        end
        repeat (40) @(negedge clock);
    endtask

    task automatic test_multi_row;
        bit found;
        bit ok;
        $display("[TB] rows 1 and 3 at col1, then extra key at col3");
        keys[1][1] = 1'b1;
        keys[3][1] = 1'b1;
        expQ.push_back(4'h5);
        waitDown(1'b1, 200, found);
        checks++;
        if (!found) begin errors++; $display("[TB] FAIL multi_down got %b exp 1", key_down); end
        checks++;
        if (key_code !== 4'h5) begin errors++; $display("[TB] FAIL multi_code got %h exp 5", key_code); end
        keys[0][3] = 1'b1;
        ok = 1'b1;
        repeat (60) begin
            if (key_down !== 1'b1 || col !== 4'b1101 || key_code !== 4'h5) ok = 1'b0;
            @(negedge clock);
        end
        checks++;
        if (!ok) begin errors++; $display("[TB] FAIL multi_ignore got code=%h col=%b exp 5/1101", key_code, col); end
        keys = '0;
        waitDown(1'b0, 100, found);
        checks++;
        if (!found) begin errors++; $display("[TB] FAIL multi_release got %b exp 0", key_down); end
        repeat (10) @(negedge clock);
        checks++;
        if (expQ.size() != 0) begin errors++; $display("[TB] FAIL multi_pulse got pending=%0d exp 0", expQ.size()); end
    endtask

    task automatic test_reset_mid;
        bit found;
        $display("[TB] reset during debounce");
        waitCol(4'b1110, 100, found);
        waitCol(4'b1101, 20, found);
        checks++;
        if (!found) begin errors++; $display("[TB] FAIL mid_reach got col=%b exp 1101", col); end
        keys[2][1] = 1'b1;
        repeat (15) @(negedge clock);
        checks++;
        if (col !== 4'b1101) begin errors++; $display("[TB] FAIL mid_freeze got col=%b exp 1101", col); end
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        checks++;
        if (col !== 4'b1110) begin errors++; $display("[TB] FAIL mid_col got %b exp 1110", col); end
        checks++;
        if (key_code !== 4'h0 || key_valid !== 1'b0 || key_down !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_outputs got code=%h valid=%b down=%b exp 0/0/0", key_code, key_valid, key_down);
        end
        keys = '0;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        repeat (80) @(negedge clock);
        checks++;
        if (key_down !== 1'b0 || key_code !== 4'h0) begin
            errors++;
            $display("[TB] FAIL mid_after got down=%b code=%h exp 0/0", key_down, key_code);
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        reset_n = 1'b0;
        keys    = '0;
        test_reset();
        test_press();
        test_release();
        test_bounce();
        test_multi_row();
        test_reset_mid();
        checks++;
        if (expQ.size() != 0) begin errors++; $display("[TB] FAIL final_queue got pending=%0d exp 0", expQ.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
